// File: rtl/wb_pkg.sv
// Shared writeback-serializer definitions: write-port kind codes, slot count, FSM states.
package wb_pkg;

    localparam logic [1:0]  WB_KIND_REG = 2'b01;
    localparam logic [1:0]  WB_KIND_SEG = 2'b10;
    localparam logic [1:0]  WB_KIND_MEM = 2'b11;
    localparam int unsigned WB_NSLOT    = 4;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_DRAIN = 1'b1
    } wb_state_e;

    // Target kind with priority reg > seg > mem; 00 when no kind bit is set.
    function automatic logic [1:0] wb_kind_sel(input logic is_reg, input logic is_seg,
                                               input logic is_mem);
        if (is_reg)      return WB_KIND_REG;
        else if (is_seg) return WB_KIND_SEG;
        else if (is_mem) return WB_KIND_MEM;
        else             return 2'b00;
    endfunction

endpackage

// File: rtl/wb_prienc4.sv
// 4-bit lowest-set-bit priority encoder: index of the lowest set bit plus an any-set flag.
module wb_prienc4 (
    input  logic [3:0] vec_i,
    output logic [1:0] idx_o,
    output logic       any_o
);

    always_comb begin
        any_o = |vec_i;
        idx_o = 2'd0;
        casez (vec_i)
            4'b???1: idx_o = 2'd0;
            4'b??10: idx_o = 2'd1;
            4'b?100: idx_o = 2'd2;
            4'b1000: idx_o = 2'd3;
            default: idx_o = 2'd0;
        endcase
    end

endmodule

// File: rtl/wb_serializer.sv
// Writeback serializer: captures a 4-slot execute bundle and retires enabled slots one per cycle.
// Optional WB_FWD_EN adds a combinational forwarding copy of the current write.
module wb_serializer
    import wb_pkg::*;
#(
    parameter int unsigned DATA_W = 64,
    parameter int unsigned ADDR_W = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  ex_valid,
    output logic                  ex_ready,
    input  logic [3:0]            ex_wb,
    input  logic [3:0]            ex_is_reg,
    input  logic [3:0]            ex_is_seg,
    input  logic [3:0]            ex_is_mem,
    input  logic [4*DATA_W-1:0]   ex_res,
    input  logic [4*ADDR_W-1:0]   ex_dest,
    input  logic [1:0]            ex_size,
    input  logic [31:0]           ex_eip,
    output logic                  wr_valid,
    input  logic                  wr_ready,
    output logic [1:0]            wr_kind,
    output logic [1:0]            wr_slot,
    output logic [ADDR_W-1:0]     wr_dest,
    output logic [DATA_W-1:0]     wr_data,
    output logic [1:0]            wr_size,
    output logic                  done,
    output logic [31:0]           done_eip,
`ifdef WB_FWD_EN
    output logic                  fwd_valid,
    output logic [ADDR_W-1:0]     fwd_dest,
    output logic [DATA_W-1:0]     fwd_data,
    output logic [1:0]            fwd_kind,
`endif
    output logic                  kind_err
);

    wb_state_e          state_q, state_d;
    logic [3:0]         pend_q, pend_d;
    logic               done_q, done_d;
    logic [31:0]        done_eip_q, done_eip_d;
    logic               kind_err_q;
    logic [DATA_W-1:0]  res_q  [WB_NSLOT];
    logic [ADDR_W-1:0]  dest_q [WB_NSLOT];
    logic [1:0]         kind_q [WB_NSLOT];
    logic [1:0]         size_q;
    logic [31:0]        eip_q;

    logic [1:0]         slot;
    logic               any_pend;
    logic [3:0]         rest;
    logic               last;
    logic               hs;
    logic               accept;
    logic [3:0]         kind_ok;
    logic [3:0]         new_pend;

    wb_prienc4 u_prienc (
        .vec_i (pend_q),
        .idx_o (slot),
        .any_o (any_pend)
    );

    assign rest     = pend_q & ~(4'b0001 << slot);
    assign last     = (rest == '0);
    assign wr_valid = any_pend;
    assign hs       = wr_valid & wr_ready;
    assign kind_ok  = ex_is_reg | ex_is_seg | ex_is_mem;
    assign new_pend = ex_wb & kind_ok;
    assign ex_ready = ~rst & ~flush & ((state_q == ST_IDLE) | (last & hs));
    assign accept   = ex_valid & ex_ready;

    // An empty bundle accepted on the final handshake of the previous one shares its
    // done cycle; the draining bundle owns done/done_eip in that case.
    always_comb begin
        pend_d     = pend_q;
        done_d     = 1'b0;
        done_eip_d = done_eip_q;
        if (flush) begin
            pend_d = '0;
        end else begin
            if (hs) begin
                pend_d = rest;
                if (last) begin
                    done_d     = 1'b1;
                    done_eip_d = eip_q;
                end
            end
            if (accept) begin
                pend_d = new_pend;
                if ((new_pend == '0) && !(hs && last)) begin
                    done_d     = 1'b1;
                    done_eip_d = ex_eip;
                end
            end
        end
        state_d = (pend_d != '0) ? ST_DRAIN : ST_IDLE;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            pend_q     <= '0;
            done_q     <= 1'b0;
            done_eip_q <= '0;
            kind_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pend_q     <= pend_d;
            done_q     <= done_d;
            done_eip_q <= done_eip_d;
            if (accept && ((ex_wb & ~kind_ok) != '0))
                kind_err_q <= 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < WB_NSLOT; i++) begin
                res_q[i]  <= '0;
                dest_q[i] <= '0;
                kind_q[i] <= '0;
            end
            size_q <= '0;
            eip_q  <= '0;
        end else if (accept) begin
            for (int unsigned i = 0; i < WB_NSLOT; i++) begin
                res_q[i]  <= ex_res[i*DATA_W +: DATA_W];
                dest_q[i] <= ex_dest[i*ADDR_W +: ADDR_W];
                kind_q[i] <= wb_kind_sel(ex_is_reg[i], ex_is_seg[i], ex_is_mem[i]);
            end
            size_q <= ex_size;
            eip_q  <= ex_eip;
        end
    end

    assign wr_slot  = slot;
    assign wr_kind  = kind_q[slot];
    assign wr_dest  = dest_q[slot];
    assign wr_data  = res_q[slot];
    assign wr_size  = size_q;
    assign done     = done_q;
    assign done_eip = done_eip_q;
    assign kind_err = kind_err_q;

`ifdef WB_FWD_EN
    assign fwd_valid = hs;
    assign fwd_dest  = wr_dest;
    assign fwd_data  = wr_data;
    assign fwd_kind  = wr_kind;
`endif

endmodule
